at_hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage Tuse/Tnew calculator for the pipelined MIPS CPU.
- Sits beside the D stage and receives per-instruction RAddr0/RAddr1/Tuse/WAddr/Tnew from the AT decoder.
- Tracks in-flight writers across NSTAGE downstream stages in a shifting scoreboard, with Tnew aging each cycle.
- Produces the D-stage stall, per-port D-stage forward selects, and a multi-cycle HI/LO busy interlock for mult/div.

---
 rtl/cpu_hazard_pkg.sv | 19 +
 rtl/at_hazard_scoreboard_if.sv | 33 +++
 rtl/at_sb_slot.sv | 43 ++++
 rtl/at_hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_at_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_hazard_pkg.sv
// Shared constants for the AT-based hazard scoreboard: Tuse sentinel, stage indices,
// forward-select encodings and mult/div latencies.
package cpu_hazard_pkg;

  localparam logic [2:0] TUSE_NONE = 3'b111;

  localparam int unsigned STG_E = 0;
  localparam int unsigned STG_M = 1;
  localparam int unsigned STG_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam int unsigned MULT_LAT_DEFAULT = 5;
  localparam int unsigned DIV_LAT_DEFAULT  = 10;

endpackage

// File: rtl/at_hazard_scoreboard_if.sv
// D-stage AT inputs and hazard outputs between the decoder and the scoreboard.
interface at_hazard_scoreboard_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 3,
  parameter int unsigned SW = 2
);
  logic          d_valid;
  logic [AW-1:0] d_raddr0;
  logic [AW-1:0] d_raddr1;
  logic [TW-1:0] d_tuse0;
  logic [TW-1:0] d_tuse1;
  logic [AW-1:0] d_waddr;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_is_div;
  logic          d_md_use;
  logic          stall;
  logic [SW-1:0] fwd_sel0;
  logic [SW-1:0] fwd_sel1;
  logic          md_busy;

  modport master (
    output d_valid, d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
           d_md_start, d_md_is_div, d_md_use,
    input  stall, fwd_sel0, fwd_sel1, md_busy
  );

  modport slave (
    input  d_valid, d_raddr0, d_raddr1, d_tuse0, d_tuse1, d_waddr, d_tnew,
           d_md_start, d_md_is_div, d_md_use,
    output stall, fwd_sel0, fwd_sel1, md_busy
  );
endinterface

// File: rtl/at_sb_slot.sv
// One scoreboard entry (dest addr, remaining Tnew). Age=1 decrements Tnew on load,
// saturating at 0; bubble_i loads an empty entry.
module at_sb_slot #(
  parameter int unsigned AW  = 5,
  parameter int unsigned TW  = 3,
  parameter bit          Age = 1'b1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          bubble_i,
  input  logic [AW-1:0] addr_i,
  input  logic [TW-1:0] tnew_i,
  output logic [AW-1:0] addr_o,
  output logic [TW-1:0] tnew_o
);
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tnew_q, tnew_d;

  always_comb begin
    addr_d = addr_i;
    tnew_d = tnew_i;
    if (Age && (tnew_i != '0)) begin
      tnew_d = tnew_i - TW'(1);
    end
    if (bubble_i) begin
      addr_d = '0;
      tnew_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      tnew_q <= '0;
    end else begin
      addr_q <= addr_d;
      tnew_q <= tnew_d;
    end
  end

  assign addr_o = addr_q;
  assign tnew_o = tnew_q;
endmodule

// File: rtl/at_hazard_scoreboard.sv
// Decode-stage hazard unit: shifting Tnew scoreboard over NSTAGE stages producing stall,
// per-port forward selects and a mult/div HI/LO busy interlock.
module at_hazard_scoreboard
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 3,
  parameter int unsigned SW       = 2,
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  at_hazard_scoreboard_if.slave hz
);
  localparam int unsigned CW = $clog2(DIV_LAT + 1);
  localparam logic [TW-1:0] TuseNone = '1;

  logic [AW-1:0] slot_addr [NSTAGE];
  logic [TW-1:0] slot_tnew [NSTAGE];

  logic [1:0][AW-1:0] raddr;
  logic [1:0][TW-1:0] tuse;
  logic [1:0]         port_stall;
  logic [1:0][SW-1:0] fwd;
  logic               hit;
  logic [TW-1:0]      hit_tnew;
  logic [SW-1:0]      hit_sel;
  logic               stall;
  logic               md_busy;
  logic [CW-1:0]      md_cnt_q, md_cnt_d;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
    if (k == STG_E) begin : g_head
      at_sb_slot #(.AW(AW), .TW(TW), .Age(1'b0)) u_slot (
        .clk_i   (clk),
        .reset_i (reset),
        .bubble_i(stall | ~hz.d_valid),
        .addr_i  (hz.d_waddr),
        .tnew_i  (hz.d_tnew),
        .addr_o  (slot_addr[k]),
        .tnew_o  (slot_tnew[k])
      );
    end else begin : g_tail
      at_sb_slot #(.AW(AW), .TW(TW), .Age(1'b1)) u_slot (
        .clk_i   (clk),
        .reset_i (reset),
        .bubble_i(1'b0),
        .addr_i  (slot_addr[k-1]),
        .tnew_i  (slot_tnew[k-1]),
        .addr_o  (slot_addr[k]),
        .tnew_o  (slot_tnew[k])
      );
    end
  end

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    raddr      = {hz.d_raddr1, hz.d_raddr0};
    tuse       = {hz.d_tuse1, hz.d_tuse0};
    port_stall = '0;
    fwd        = '0;
    hit        = 1'b0;
    hit_tnew   = '0;
    hit_sel    = '0;
    for (int p = 0; p < 2; p++) begin
      hit      = 1'b0;
      hit_tnew = '0;
      hit_sel  = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if ((raddr[p] != '0) && (slot_addr[k] == raddr[p])) begin
          hit      = 1'b1;
          hit_tnew = slot_tnew[k];
          hit_sel  = SW'(k + 1);
        end
      end
      port_stall[p] = hit && (tuse[p] != TuseNone) && (hit_tnew > tuse[p]);
      fwd[p]        = (hit && (hit_tnew == '0)) ? hit_sel : SW'(FWD_RF);
    end
  end

  assign md_busy = (md_cnt_q != '0);
  assign stall   = port_stall[0] | port_stall[1] | (hz.d_md_use & md_busy);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.d_md_start && hz.d_valid && !stall) begin
      md_cnt_d = hz.d_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.stall    = stall;
  assign hz.fwd_sel0 = fwd[0];
  assign hz.fwd_sel1 = fwd[1];
  assign hz.md_busy  = md_busy;
endmodule

// File: tb/tb_at_hazard_scoreboard.sv
// Directed-vector bench for at_hazard_scoreboard: load-use, jal/jr, $0, Tuse-none,
// youngest-match, mult/div interlock and mid-operation reset.
module tb_at_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  at_hazard_scoreboard_if hz ();

  at_hazard_scoreboard dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [2:0] u0, input logic [2:0] u1, input logic [4:0] wa,
                       input logic [2:0] tn, input logic ms, input logic md, input logic mu);
    hz.d_valid     = v;
    hz.d_raddr0    = r0;
    hz.d_raddr1    = r1;
    hz.d_tuse0     = u0;
    hz.d_tuse1     = u1;
    hz.d_waddr     = wa;
    hz.d_tnew      = tn;
    hz.d_md_start  = ms;
    hz.d_md_is_div = md;
    hz.d_md_use    = mu;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd0) begin errors++;
      $display("FAIL reset_fwd0: got %0d want 0", hz.fwd_sel0); end
    checks++; if (hz.fwd_sel1 !== 2'd0) begin errors++;
      $display("FAIL reset_fwd1: got %0d want 0", hz.fwd_sel1); end
    checks++; if (hz.md_busy !== 1'b0) begin errors++;
      $display("FAIL reset_md_busy: got %b want 0", hz.md_busy); end
  endtask

  // lw $1 (tnew 2); beq $1,$2 (tuse 0): two stalls, then forward from W.
  task automatic test_load_use_branch();
    drive(1'b1, 5'd29, 5'd0, 3'd1, 3'd7, 5'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL lub_lw_stall: got %b want 0", hz.stall); end
    tick();
    drive(1'b1, 5'd1, 5'd2, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      checks++; if (hz.stall !== 1'b1) begin errors++;
        $display("FAIL lub_stall c%0d: got %b want 1", c, hz.stall); end
      tick();
    end
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL lub_release: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd3) begin errors++;
      $display("FAIL lub_fwd0: got %0d want 3", hz.fwd_sel0); end
    checks++; if (hz.fwd_sel1 !== 2'd0) begin errors++;
      $display("FAIL lub_fwd1: got %0d want 0", hz.fwd_sel1); end
    tick();
    flush(4);
  endtask

  // lw $3; addu $4,$3,$5 (tuse 1): one stall.
  task automatic test_load_use_alu();
    drive(1'b1, 5'd29, 5'd0, 3'd1, 3'd7, 5'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd5, 3'd1, 3'd1, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b1) begin errors++;
      $display("FAIL lua_stall: got %b want 1", hz.stall); end
    tick();
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL lua_release: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd0) begin errors++;
      $display("FAIL lua_fwd0: got %0d want 0", hz.fwd_sel0); end
    checks++; if (hz.fwd_sel1 !== 2'd0) begin errors++;
      $display("FAIL lua_fwd1: got %0d want 0", hz.fwd_sel1); end
    tick();
    flush(4);
  endtask

  // addu $4 (tnew 1); subu $6,$7,$4; writer $10 (tnew 0) reading $4,$4; reader $6,$10.
  task automatic test_alu_forward();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd4, 3'd1, 3'd1, 5'd6, 3'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL alu_i2_stall: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel1 !== 2'd0) begin errors++;
      $display("FAIL alu_i2_fwd1: got %0d want 0", hz.fwd_sel1); end
    tick();
    drive(1'b1, 5'd4, 5'd4, 3'd1, 3'd1, 5'd10, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.fwd_sel0 !== 2'd2) begin errors++;
      $display("FAIL alu_i3_fwd0: got %0d want 2", hz.fwd_sel0); end
    checks++; if (hz.fwd_sel1 !== 2'd2) begin errors++;
      $display("FAIL alu_i3_fwd1: got %0d want 2", hz.fwd_sel1); end
    tick();
    drive(1'b1, 5'd6, 5'd10, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL alu_i4_stall: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd2) begin errors++;
      $display("FAIL alu_i4_fwd0: got %0d want 2", hz.fwd_sel0); end
    checks++; if (hz.fwd_sel1 !== 2'd1) begin errors++;
      $display("FAIL alu_i4_fwd1: got %0d want 1", hz.fwd_sel1); end
    tick();
    flush(4);
  endtask

  // Two writers of $4; the younger (not ready) must govern, not the older ready one.
  task automatic test_youngest();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd4, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b1) begin errors++;
      $display("FAIL young_stall: got %b want 1", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd0) begin errors++;
      $display("FAIL young_fwd0: got %0d want 0", hz.fwd_sel0); end
    tick();
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL young_release: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd2) begin errors++;
      $display("FAIL young_fwd0_m: got %0d want 2", hz.fwd_sel0); end
    tick();
    flush(4);
  endtask

  task automatic test_jal_jr();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd31, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd31, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b1) begin errors++;
      $display("FAIL jr_stall: got %b want 1", hz.stall); end
    tick();
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL jr_release: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd2) begin errors++;
      $display("FAIL jr_fwd0: got %0d want 2", hz.fwd_sel0); end
    tick();
    flush(4);
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (hz.stall !== 1'b0) begin errors++;
        $display("FAIL zero_stall c%0d: got %b want 0", c, hz.stall); end
      checks++; if ({hz.fwd_sel0, hz.fwd_sel1} !== 4'd0) begin errors++;
        $display("FAIL zero_fwd c%0d: got %0d/%0d want 0/0", c, hz.fwd_sel0, hz.fwd_sel1); end
      tick();
    end
    flush(4);
  endtask

  task automatic test_tuse_none();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd8, 3'd7, 3'd7, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL tnone_stall: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd0) begin errors++;
      $display("FAIL tnone_fwd0: got %0d want 0", hz.fwd_sel0); end
    tick();
    flush(4);
  endtask

  // md op issued, then mflo waits lat cycles on md_busy.
  task automatic test_md(input logic is_div, input int lat);
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b1, is_div, 1'b1);
    checks++; if ({hz.stall, hz.md_busy} !== 2'b00) begin errors++;
      $display("FAIL md%0d_issue: got stall/busy %b want 00", lat, {hz.stall, hz.md_busy}); end
    tick();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd9, 3'd1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < lat; c++) begin
      checks++; if ({hz.stall, hz.md_busy} !== 2'b11) begin errors++;
        $display("FAIL md%0d_busy c%0d: got stall/busy %b want 11", lat, c,
                 {hz.stall, hz.md_busy}); end
      tick();
    end
    checks++; if ({hz.stall, hz.md_busy} !== 2'b00) begin errors++;
      $display("FAIL md%0d_done: got stall/busy %b want 00", lat, {hz.stall, hz.md_busy}); end
    tick();
    flush(4);
  endtask

  // mult stalled on a load-use is not accepted until the stall clears.
  task automatic test_md_start_stalled();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd0, 3'd1, 3'd7, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (hz.stall !== 1'b1) begin errors++;
      $display("FAIL mds_stall: got %b want 1", hz.stall); end
    tick();
    checks++; if ({hz.stall, hz.md_busy} !== 2'b00) begin errors++;
      $display("FAIL mds_not_taken: got stall/busy %b want 00", {hz.stall, hz.md_busy}); end
    tick();
    idle();
    checks++; if (hz.md_busy !== 1'b1) begin errors++;
      $display("FAIL mds_taken: got %b want 1", hz.md_busy); end
    flush(8);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd0, 3'd0, 3'd7, 5'd9, 3'd1, 1'b0, 1'b0, 1'b1);
    checks++; if ({hz.stall, hz.md_busy} !== 2'b11) begin errors++;
      $display("FAIL rmid_pre: got stall/busy %b want 11", {hz.stall, hz.md_busy}); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (hz.md_busy !== 1'b0) begin errors++;
      $display("FAIL rmid_busy: got %b want 0", hz.md_busy); end
    checks++; if (hz.stall !== 1'b0) begin errors++;
      $display("FAIL rmid_stall: got %b want 0", hz.stall); end
    checks++; if (hz.fwd_sel0 !== 2'd0) begin errors++;
      $display("FAIL rmid_fwd0: got %0d want 0", hz.fwd_sel0); end
    tick();
    flush(4);
  endtask

  initial begin
    test_reset();
    test_load_use_branch();
    test_load_use_alu();
    test_alu_forward();
    test_youngest();
    test_jal_jr();
    test_zero_reg();
    test_tuse_none();
    test_md(1'b1, 10);
    test_md(1'b0, 5);
    test_md_start_stalled();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
